// File: rtl/step_ctrl_pkg.sv
// Shared types and default parameters for the step/run issue controller.
package step_ctrl_pkg;

    localparam int unsigned RUN_DIV_DEF   = 4;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned BURST_LEN_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= async_in;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Single-step / free-run instruction issue controller with CPU completion handshake.
// Define STEP_CTRL_BURST_EN to add the burst_in port and fixed-length burst issue.
module step_ctrl #(
    parameter int unsigned RUN_DIV   = step_ctrl_pkg::RUN_DIV_DEF,
    parameter int unsigned CNT_W     = step_ctrl_pkg::CNT_W_DEF,
    parameter int unsigned BURST_LEN = step_ctrl_pkg::BURST_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             run_in,
`ifdef STEP_CTRL_BURST_EN
    input  logic             burst_in,
`endif
    input  logic             cpu_done,
    input  logic             halt,
    output logic             cpu_en,
    output logic             running,
    output logic             busy,
    output logic [CNT_W-1:0] steps
);

    import step_ctrl_pkg::*;

    localparam int unsigned GAP_W = 16;

    // Elaboration-time parameter range guards
    if (RUN_DIV < 1 || RUN_DIV > 65535) begin : g_bad_run_div
        $error("step_ctrl: RUN_DIV out of range 1..65535");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("step_ctrl: BURST_LEN out of range 1..255");
    end

    state_t             state;
    state_t             state_nxt;
    logic               running_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;
    logic               step_edge;
    logic               run_edge;
    logic               keep_going;

    sync_edge u_step_sync (.clk(clk), .reset(reset), .async_in(step_in), .pulse(step_edge));
    sync_edge u_run_sync  (.clk(clk), .reset(reset), .async_in(run_in),  .pulse(run_edge));

`ifdef STEP_CTRL_BURST_EN
    localparam int unsigned BURST_W = 8;

    logic               burst_edge;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_nxt;

    sync_edge u_burst_sync (.clk(clk), .reset(reset), .async_in(burst_in), .pulse(burst_edge));

    // burst_cnt holds the number of instructions still to issue after the current one
    assign keep_going = (running && !run_edge) || (burst_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) burst_cnt <= '0;
        else       burst_cnt <= burst_nxt;
    end
`else
    assign keep_going = running && !run_edge;
`endif

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        running_nxt = running;
        gap_nxt     = gap_cnt;
`ifdef STEP_CTRL_BURST_EN
        burst_nxt   = burst_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (!halt) begin
                    if (run_edge) begin
                        running_nxt = 1'b1;
                        state_nxt   = ST_ISSUE;
                    end
`ifdef STEP_CTRL_BURST_EN
                    else if (burst_edge) begin
                        burst_nxt = BURST_W'(BURST_LEN);
                        state_nxt = ST_ISSUE;
                    end
`endif
                    else if (step_edge) begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
                if (run_edge) running_nxt = 1'b0;
`ifdef STEP_CTRL_BURST_EN
                if (burst_cnt != '0) burst_nxt = burst_cnt - BURST_W'(1);
`endif
            end
            ST_WAIT: begin
                if (run_edge) running_nxt = 1'b0;
                if (cpu_done) begin
                    if (halt) begin
                        running_nxt = 1'b0;
`ifdef STEP_CTRL_BURST_EN
                        burst_nxt   = '0;
`endif
                        state_nxt   = ST_IDLE;
                    end else if (keep_going) begin
                        gap_nxt   = GAP_W'(RUN_DIV - 1);
                        state_nxt = ST_GAP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                // A run toggle or halt abandons the pending issue
                if (run_edge || halt) begin
                    running_nxt = 1'b0;
`ifdef STEP_CTRL_BURST_EN
                    burst_nxt   = '0;
`endif
                    state_nxt   = ST_IDLE;
                end else if (gap_cnt == '0) begin
                    state_nxt = ST_ISSUE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; cpu_en/busy/steps track the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            gap_cnt <= '0;
            cpu_en  <= 1'b0;
            busy    <= 1'b0;
            steps   <= '0;
        end else begin
            state   <= state_nxt;
            running <= running_nxt;
            gap_cnt <= gap_nxt;
            cpu_en  <= (state_nxt == ST_ISSUE);
            busy    <= (state_nxt != ST_IDLE);
            if (state_nxt == ST_ISSUE) steps <= steps + CNT_W'(1);
        end
    end

endmodule
